// File: rtl/branch_ctrl.sv
// Branch/jump controller: decodes branch-class instructions, drives registered
// PC redirect and flush, keeps a 4-deep return-address stack and a 16x8 target LUT.
module branch_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pc,
    input  logic [8:0] instr,
    input  logic       instr_valid,
    input  logic       flag_zero,
    input  logic       flag_lt,
    input  logic       lut_we,
    input  logic [3:0] lut_addr,
    input  logic [7:0] lut_data,
    output logic       jump_en,
    output logic [7:0] jump_target,
    output logic       flush,
    output logic       done,
    output logic [2:0] ras_depth,
    output logic       stack_err,
    output logic       dbg_state
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic       jump_q, jump_d;
    logic       flush_q, flush_d;
    logic       done_q, done_d;
    logic [7:0] target_q, target_d;
    logic       err_q, err_d;
    logic [2:0] depth_q, depth_d;
    logic [7:0] ras_q [4];
    logic [7:0] ras_d [4];
    logic [7:0] lut_q [16];

    logic       dec_en;
    logic [1:0] op;
    logic [3:0] idx;
    logic [7:0] lut_rd;
    logic [1:0] top_idx;
    logic [7:0] ret_addr;
    logic [7:0] push_addr;

    assign op        = instr[5:4];
    assign idx       = instr[3:0];
    // Instruction in the shadow of a taken jump (flush high) is never decoded.
    assign dec_en    = (state_q == ST_RUN) && instr_valid && !flush_q && (instr[8:6] == 3'b111);
    assign lut_rd    = lut_q[idx];
    assign top_idx   = depth_q[1:0] - 2'd1;
    assign ret_addr  = ras_q[top_idx];
    assign push_addr = pc + 8'd1;

    always_comb begin
        state_d  = state_q;
        jump_d   = 1'b0;
        flush_d  = 1'b0;
        done_d   = done_q;
        target_d = target_q;
        err_d    = err_q;
        depth_d  = depth_q;
        ras_d    = ras_q;
        case (state_q)
            ST_RUN: begin
                if (dec_en) begin
                    case (op)
                        2'b00: begin
                            if (flag_zero) begin
                                jump_d   = 1'b1;
                                flush_d  = 1'b1;
                                target_d = lut_rd;
                            end
                        end
                        2'b01: begin
                            if (flag_lt) begin
                                jump_d   = 1'b1;
                                flush_d  = 1'b1;
                                target_d = lut_rd;
                            end
                        end
                        2'b10: begin
                            // A full stack drops the push but the call still jumps.
                            jump_d   = 1'b1;
                            flush_d  = 1'b1;
                            target_d = lut_rd;
                            if (depth_q == 3'd4) begin
                                err_d = 1'b1;
                            end else begin
                                ras_d[depth_q[1:0]] = push_addr;
                                depth_d             = depth_q + 3'd1;
                            end
                        end
                        default: begin
                            if (instr[3]) begin
                                state_d  = ST_HALTED;
                                done_d   = 1'b1;
                                jump_d   = 1'b1;
                                flush_d  = 1'b1;
                                target_d = pc;
                            end else if (depth_q != 3'd0) begin
                                jump_d   = 1'b1;
                                flush_d  = 1'b1;
                                target_d = ret_addr;
                                depth_d  = depth_q - 3'd1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_HALTED: begin
                // Keep redirecting the PC to the HALT address so fetch stays frozen.
                jump_d  = 1'b1;
                flush_d = 1'b1;
                done_d  = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            jump_q   <= 1'b0;
            flush_q  <= 1'b0;
            done_q   <= 1'b0;
            target_q <= 8'd0;
            err_q    <= 1'b0;
            depth_q  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                ras_q[i] <= 8'd0;
            end
        end else begin
            state_q  <= state_d;
            jump_q   <= jump_d;
            flush_q  <= flush_d;
            done_q   <= done_d;
            target_q <= target_d;
            err_q    <= err_d;
            depth_q  <= depth_d;
            ras_q    <= ras_d;
        end
    end

    // LUT reads are combinational from the stored array, so a same-cycle write is not visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                lut_q[i] <= 8'd0;
            end
        end else if (lut_we) begin
            lut_q[lut_addr] <= lut_data;
        end
    end

    assign jump_en     = jump_q;
    assign flush       = flush_q;
    assign done        = done_q;
    assign jump_target = target_q;
    assign ras_depth   = depth_q;
    assign stack_err   = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios then random traffic, all checked
// against a queue/array reference model of the branch, stack and LUT rules.
module tb_branch_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] pc;
    logic [8:0] instr;
    logic       instr_valid;
    logic       flag_zero;
    logic       flag_lt;
    logic       lut_we;
    logic [3:0] lut_addr;
    logic [7:0] lut_data;
    logic       jump_en;
    logic [7:0] jump_target;
    logic       flush;
    logic       done;
    logic [2:0] ras_depth;
    logic       stack_err;
    logic       dbg_state;

    branch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .flag_zero   (flag_zero),
        .flag_lt     (flag_lt),
        .lut_we      (lut_we),
        .lut_addr    (lut_addr),
        .lut_data    (lut_data),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .flush       (flush),
        .done        (done),
        .ras_depth   (ras_depth),
        .stack_err   (stack_err),
        .dbg_state   (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int         ras_m[$];
    logic [7:0] lut_m [16];
    logic       m_halted, m_jump, m_flush, m_done, m_err;
    logic [7:0] m_tgt;
    logic       m_tgt_chk;

    // Expected {jump, flush, done, target, depth, err, target_check}
    logic [15:0] exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [8:0] NOP  = 9'b000_00_0000;
    localparam logic [8:0] RET  = 9'b111_11_0000;
    localparam logic [8:0] HALT = 9'b111_11_1000;

    function automatic logic [8:0] bz(input logic [3:0] i);
        return {3'b111, 2'b00, i};
    endfunction
    function automatic logic [8:0] blt(input logic [3:0] i);
        return {3'b111, 2'b01, i};
    endfunction
    function automatic logic [8:0] call(input logic [3:0] i);
        return {3'b111, 2'b10, i};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic       take;
        logic [7:0] tgt;
        if (reset) begin
            m_halted = 1'b0; m_jump = 1'b0; m_flush = 1'b0; m_done = 1'b0;
            m_err = 1'b0; m_tgt = 8'd0; m_tgt_chk = 1'b1;
            ras_m.delete();
            for (int i = 0; i < 16; i++) lut_m[i] = 8'd0;
        end else begin
            m_tgt_chk = 1'b0;
            if (m_halted) begin
                m_jump = 1'b1; m_flush = 1'b1; m_done = 1'b1; m_tgt_chk = 1'b1;
            end else begin
                take = 1'b0;
                tgt  = m_tgt;
                if (instr_valid && !m_flush && instr[8:6] == 3'b111) begin
                    case (instr[5:4])
                        2'd0: if (flag_zero) begin take = 1'b1; tgt = lut_m[instr[3:0]]; end
                        2'd1: if (flag_lt) begin take = 1'b1; tgt = lut_m[instr[3:0]]; end
                        2'd2: begin
                            take = 1'b1;
                            tgt  = lut_m[instr[3:0]];
                            if (ras_m.size() == 4) m_err = 1'b1;
                            else ras_m.push_back((int'(pc) + 1) % 256);
                        end
                        default: begin
                            if (instr[3]) begin
                                m_halted = 1'b1; m_done = 1'b1; take = 1'b1; tgt = pc;
                            end else if (ras_m.size() > 0) begin
                                take = 1'b1; tgt = 8'(ras_m.pop_back());
                            end else begin
                                m_err = 1'b1;
                            end
                        end
                    endcase
                end
                m_jump = take; m_flush = take; m_tgt = tgt; m_tgt_chk = take;
            end
            if (lut_we) lut_m[lut_addr] = lut_data;
        end
        exp_q.push_back({m_jump, m_flush, m_done, m_tgt, 3'(ras_m.size()), m_err, m_tgt_chk});
    endtask

    // Driver: apply one cycle of inputs, update the model at the edge, check 1 time unit later.
    task automatic step(input logic rst, input logic [7:0] p, input logic [8:0] ins,
                        input logic v, input logic fz, input logic fl,
                        input logic we, input logic [3:0] wa, input logic [7:0] wd);
        logic [15:0] e;
        reset = rst; pc = p; instr = ins; instr_valid = v;
        flag_zero = fz; flag_lt = fl; lut_we = we; lut_addr = wa; lut_data = wd;
        @(posedge clk);
        model_step();
        #1;
        e = exp_q.pop_front();
        check("jump_en",   {7'd0, jump_en},   {7'd0, e[15]});
        check("flush",     {7'd0, flush},     {7'd0, e[14]});
        check("done",      {7'd0, done},      {7'd0, e[13]});
        check("ras_depth", {5'd0, ras_depth}, {5'd0, e[4:2]});
        check("stack_err", {7'd0, stack_err}, {7'd0, e[1]});
        if (e[0]) check("jump_target", jump_target, e[12:5]);
    endtask

    task automatic idle(input logic [7:0] p);
        step(1'b0, p, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        step(1'b0, 8'd0, NOP, 1'b0, 1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic do_reset();
        step(1'b1, 8'd0, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    initial begin
        logic [8:0] ins;
        #2;
        do_reset();
        do_reset();

        // BZ taken, then the flushed shadow instruction is ignored
        wr(4'd3, 8'h40);
        step(1'b0, 8'd10, bz(4'd3), 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        step(1'b0, 8'd11, bz(4'd3), 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        idle(8'd12);

        // BLT not taken; next instruction decodes normally
        step(1'b0, 8'd12, blt(4'd3), 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        step(1'b0, 8'd13, bz(4'd3), 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        idle(8'd14);

        // CALL at pc=255 wraps the return address to 0
        wr(4'd1, 8'h80);
        step(1'b0, 8'd255, call(4'd1), 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        idle(8'h80);
        step(1'b0, 8'h81, RET, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        idle(8'd0);

        // Overflow then underflow
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'(100 + i), call(4'd1), 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
            idle(8'h80);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h90, RET, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
            idle(8'h91);
        end

        // HALT freezes the PC; later branches ignored; LUT writes accepted; reset exits
        do_reset();
        step(1'b0, 8'd20, HALT, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        step(1'b0, 8'd21, bz(4'd0), 1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 8'h33);
        step(1'b0, 8'd20, bz(4'd0), 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        do_reset();

        // Branch and LUT write during reset are overridden
        wr(4'd2, 8'h55);
        step(1'b0, 8'd30, call(4'd2), 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        idle(8'h55);
        step(1'b1, 8'd40, bz(4'd2), 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 8'h66);
        step(1'b0, 8'd41, bz(4'd2), 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        idle(8'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) != 0) ins = {3'b111, 6'($urandom)};
            else ins = 9'($urandom);
            if (ins[8:6] == 3'b111 && ins[5:4] == 2'b11 && ins[3] && $urandom_range(0, 7) != 0)
                ins[3] = 1'b0;
            step($urandom_range(0, 39) == 0, 8'($urandom), ins, $urandom_range(0, 4) != 0,
                 1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0,
                 4'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
